// File: rtl/game_logic.sv
// game_logic: single local player kitchen game engine.
// A welcome menu edits a three-letter team name. A timed round follows in which
// the player moves, carries, chops onions, plates them and serves orders.
// Every output is a register updated one cycle after the detected edge.
module game_logic #(
    parameter int ROUND_SECONDS  = 120,
    parameter int FRAMES_PER_SEC = 60,
    parameter int CHOPS_NEEDED   = 4,
    parameter int ORDER_PERIOD   = 10,
    parameter int ORDER_LIFETIME = 20,
    parameter int MOVE_STEP      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic [1:0]            local_player_ID,
    input  logic [1:0]            num_players,
    input  logic                  left,
    input  logic                  right,
    input  logic                  up,
    input  logic                  down,
    input  logic                  chop,
    input  logic                  carry,
    output logic [2:0]            game_state,
    output logic [7:0][12:0][3:0] object_grid,
    output logic [7:0][12:0][3:0] time_grid,
    output logic [7:0]            time_left,
    output logic [9:0]            point_total,
    output logic [3:0]            orders,
    output logic [3:0][4:0]       order_times,
    output logic [2:0][7:0]       team_name,
    output logic [1:0]            player_direction,
    output logic [8:0]            player_loc_x,
    output logic [8:0]            player_loc_y,
    output logic [3:0]            player_state
);

    localparam logic [3:0] OBJ_EMPTY   = 4'd0;
    localparam logic [3:0] OBJ_ONION   = 4'd1;
    localparam logic [3:0] OBJ_CHOPPED = 4'd2;
    localparam logic [3:0] OBJ_PLATE   = 4'd3;
    localparam logic [3:0] OBJ_PLATED  = 4'd4;
    localparam logic [8:0] X_MIN   = 9'd32;
    localparam logic [8:0] X_MAX   = 9'd352;
    localparam logic [8:0] Y_MIN   = 9'd32;
    localparam logic [8:0] Y_MAX   = 9'd192;
    localparam logic [8:0] X_START = 9'd192;
    localparam logic [8:0] Y_START = 9'd128;
    localparam logic [8:0] STEP    = 9'(MOVE_STEP);
    localparam logic [7:0] CHAR_A  = 8'h41;
    localparam logic [7:0] CHAR_Z  = 8'h5A;

    typedef enum logic [2:0] {WELCOME = 3'd0, PLAY = 3'd1, GAME_OVER = 3'd2} state_t;

    state_t     state;
    logic [1:0] cursor;
    logic [7:0] frame_cnt, sec_cnt;
    logic [1:0] players_q, player_id_q;
    logic       vsync_q, left_q, right_q, up_q, down_q, chop_q, carry_q;
    logic       frame_e, left_e, right_e, up_e, down_e, chop_e, carry_e;
    logic [8:0] nx, ny;
    logic [1:0] ndir;
    logic [9:0] cx, cy, fx, fy;
    logic [2:0] f_row;
    logic [3:0] f_col, tile_obj, tile_tg;
    logic       at_crate, at_board, at_plates, at_window, at_counter;
    logic       frame_wrap, sec_tick, spawn_due, slot_taken;
    logic [3:0] ord_t;
    logic [3:0][4:0] ot_t;
    logic [9:0] pts_t;
    logic [1:0] serve_slot;
    logic       unused_info;

    assign game_state = state;
    assign frame_e = vsync & ~vsync_q;
    assign left_e  = left  & ~left_q;
    assign right_e = right & ~right_q;
    assign up_e    = up    & ~up_q;
    assign down_e  = down  & ~down_q;
    assign chop_e  = chop  & ~chop_q;
    assign carry_e = carry & ~carry_q;

    assign frame_wrap = (frame_cnt == 8'(FRAMES_PER_SEC - 1));
    assign sec_tick   = (state == PLAY) & frame_e & frame_wrap;
    assign spawn_due  = (sec_cnt == 8'(ORDER_PERIOD - 1));

    // Player id and count are kept for other layers but drive no game logic.
    assign unused_info = ^{players_q, player_id_q, fx[9], fx[4:0], fy[9:8], fy[4:0]};

    // Next position/direction for a frame tick: up > down > left > right, clamped to the interior.
    always_comb begin
        nx   = player_loc_x;
        ny   = player_loc_y;
        ndir = player_direction;
        if (up) begin
            ndir = 2'd0;
            ny   = (player_loc_y < Y_MIN + STEP) ? Y_MIN : player_loc_y - STEP;
        end else if (down) begin
            ndir = 2'd2;
            ny   = (player_loc_y + STEP > Y_MAX) ? Y_MAX : player_loc_y + STEP;
        end else if (left) begin
            ndir = 2'd3;
            nx   = (player_loc_x < X_MIN + STEP) ? X_MIN : player_loc_x - STEP;
        end else if (right) begin
            ndir = 2'd1;
            nx   = (player_loc_x + STEP > X_MAX) ? X_MAX : player_loc_x + STEP;
        end
    end

    // Faced tile: sprite centre pushed one tile in the facing direction, then classified.
    always_comb begin
        cx = {1'b0, player_loc_x} + 10'd16;
        cy = {1'b0, player_loc_y} + 10'd16;
        fx = cx;
        fy = cy;
        case (player_direction)
            2'd0:    fy = cy - 10'd32;
            2'd1:    fx = cx + 10'd32;
            2'd2:    fy = cy + 10'd32;
            default: fx = cx - 10'd32;
        endcase
        f_col      = fx[8:5];
        f_row      = fy[7:5];
        tile_obj   = object_grid[f_row][f_col];
        tile_tg    = time_grid[f_row][f_col];
        at_crate   = (f_row == 3'd3) && (f_col == 4'd0);
        at_board   = (f_row == 3'd0) && (f_col == 4'd6);
        at_plates  = (f_row == 3'd7) && (f_col == 4'd6);
        at_window  = (f_row == 3'd3) && (f_col == 4'd12);
        at_counter = ((f_row == 3'd0) || (f_row == 3'd7) || (f_col == 4'd0) || (f_col == 4'd12))
                     && !at_crate && !at_board && !at_plates && !at_window;
    end

    // Once-per-second order bookkeeping: age orders, charge expiries, then spawn into the lowest free slot.
    always_comb begin
        ord_t      = orders;
        ot_t       = order_times;
        pts_t      = point_total;
        slot_taken = 1'b0;
        if (sec_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (orders[i]) begin
                    if (order_times[i] <= 5'd1) begin
                        ord_t[i] = 1'b0;
                        ot_t[i]  = 5'd0;
                        pts_t    = (pts_t >= 10'd10) ? pts_t - 10'd10 : 10'd0;
                    end else begin
                        ot_t[i] = order_times[i] - 5'd1;
                    end
                end
            end
            if (spawn_due) begin
                for (int i = 0; i < 4; i++) begin
                    if (!slot_taken && !ord_t[i]) begin
                        ord_t[i]   = 1'b1;
                        ot_t[i]    = 5'(ORDER_LIFETIME);
                        slot_taken = 1'b1;
                    end
                end
            end
        end
    end

    // Lowest active order slot, the one a served dish satisfies.
    always_comb begin
        serve_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ord_t[i]) serve_slot = 2'(i);
        end
    end

    // Game state machine: edge history, menu editing, round play and the frozen end screen.
    always_ff @(posedge clock) begin
        vsync_q <= vsync;
        left_q  <= left;
        right_q <= right;
        up_q    <= up;
        down_q  <= down;
        chop_q  <= chop;
        carry_q <= carry;
        if (reset || (state == GAME_OVER && chop_e)) begin
            state            <= WELCOME;
            cursor           <= 2'd0;
            object_grid      <= '0;
            time_grid        <= '0;
            time_left        <= 8'(ROUND_SECONDS);
            point_total      <= '0;
            orders           <= '0;
            order_times      <= '0;
            player_loc_x     <= X_START;
            player_loc_y     <= Y_START;
            player_direction <= 2'd2;
            player_state     <= OBJ_EMPTY;
            frame_cnt        <= '0;
            sec_cnt          <= '0;
            if (reset) begin
                team_name   <= {CHAR_A, CHAR_A, CHAR_A};
                players_q   <= '0;
                player_id_q <= '0;
            end
        end else begin
            case (state)
                WELCOME: begin
                    if (up_e)
                        team_name[cursor] <= (team_name[cursor] == CHAR_Z) ? CHAR_A : team_name[cursor] + 8'd1;
                    else if (down_e)
                        team_name[cursor] <= (team_name[cursor] == CHAR_A) ? CHAR_Z : team_name[cursor] - 8'd1;
                    if (right_e && cursor != 2'd2)
                        cursor <= cursor + 2'd1;
                    else if (left_e && cursor != 2'd0)
                        cursor <= cursor - 2'd1;
                    if (chop_e) begin
                        players_q   <= num_players;
                        player_id_q <= local_player_ID;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (frame_e) begin
                        player_loc_x     <= nx;
                        player_loc_y     <= ny;
                        player_direction <= ndir;
                        frame_cnt        <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;
                        if (frame_wrap) begin
                            time_left <= time_left - 8'd1;
                            sec_cnt   <= spawn_due ? 8'd0 : sec_cnt + 8'd1;
                            if (time_left == 8'd1) state <= GAME_OVER;
                        end
                    end
                    orders      <= ord_t;
                    order_times <= ot_t;
                    point_total <= pts_t;
                    if (carry_e) begin
                        if (player_state == OBJ_EMPTY) begin
                            if (at_crate)
                                player_state <= OBJ_ONION;
                            else if (at_plates)
                                player_state <= OBJ_PLATE;
                            else if ((at_counter || at_board) && tile_obj != OBJ_EMPTY) begin
                                player_state               <= tile_obj;
                                object_grid[f_row][f_col] <= OBJ_EMPTY;
                                time_grid[f_row][f_col]   <= 4'd0;
                            end
                        end else if (player_state == OBJ_PLATE && at_board && tile_obj == OBJ_CHOPPED) begin
                            player_state               <= OBJ_PLATED;
                            object_grid[f_row][f_col] <= OBJ_EMPTY;
                        end else if (player_state == OBJ_PLATED && at_window) begin
                            if (|ord_t) begin
                                orders[serve_slot]      <= 1'b0;
                                order_times[serve_slot] <= 5'd0;
                                point_total  <= (pts_t > 10'd1003) ? 10'd1023 : pts_t + 10'd20;
                                player_state <= OBJ_EMPTY;
                            end
                        end else if ((at_counter || at_board) && tile_obj == OBJ_EMPTY) begin
                            object_grid[f_row][f_col] <= player_state;
                            player_state               <= OBJ_EMPTY;
                        end
                    end else if (chop_e && at_board && tile_obj == OBJ_ONION) begin
                        if (tile_tg + 4'd1 == 4'(CHOPS_NEEDED)) begin
                            object_grid[f_row][f_col] <= OBJ_CHOPPED;
                            time_grid[f_row][f_col]   <= 4'd0;
                        end else begin
                            time_grid[f_row][f_col] <= tile_tg + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_logic.sv
// Testbench for game_logic: menu vectors from a table, a scripted kitchen round
// from a step table, then timed sequences for orders, round end and reset.
module tb_game_logic;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_CHOP = 4, B_CARRY = 5;
    localparam int NONE = -1;
    localparam int LA = 8'h41, LB = 8'h42, LC = 8'h43, LD = 8'h44, LY = 8'h59, LZ = 8'h5A;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  vsync = 1'b0;
    logic [1:0]            local_player_ID = 2'd1;
    logic [1:0]            num_players = 2'd2;
    logic                  left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic                  chop = 1'b0, carry = 1'b0;
    logic [2:0]            game_state;
    logic [7:0][12:0][3:0] object_grid;
    logic [7:0][12:0][3:0] time_grid;
    logic [7:0]            time_left;
    logic [9:0]            point_total;
    logic [3:0]            orders;
    logic [3:0][4:0]       order_times;
    logic [2:0][7:0]       team_name;
    logic [1:0]            player_direction;
    logic [8:0]            player_loc_x, player_loc_y;
    logic [3:0]            player_state;

    game_logic dut (
        .clock(clock), .reset(reset), .vsync(vsync),
        .local_player_ID(local_player_ID), .num_players(num_players),
        .left(left), .right(right), .up(up), .down(down), .chop(chop), .carry(carry),
        .game_state(game_state), .object_grid(object_grid), .time_grid(time_grid),
        .time_left(time_left), .point_total(point_total), .orders(orders),
        .order_times(order_times), .team_name(team_name),
        .player_direction(player_direction), .player_loc_x(player_loc_x),
        .player_loc_y(player_loc_y), .player_state(player_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int btn;
        int e0, e1, e2;
    } wv_t;

    typedef struct {
        int mv, n, act;
        int ex, ey, edir, est;
        int tr, tc, eobj, etg;
    } step_t;

    int checks = 0;
    int errors = 0;
    int nframes = 0;
    wv_t   wv[11];
    step_t st[20];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_UP:    up = v;
            B_DOWN:  down = v;
            B_LEFT:  left = v;
            B_RIGHT: right = v;
            B_CHOP:  chop = v;
            default: carry = v;
        endcase
    endtask

    task automatic press(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            set_btn(b, 1'b1);
            repeat (20) @(negedge clock);
            set_btn(b, 1'b0);
            repeat (20) @(negedge clock);
        end
    endtask

    task automatic run_frames(input int mv, input int n);
        if (mv != NONE) set_btn(mv, 1'b1);
        for (int k = 0; k < n; k++) begin
            vsync = 1'b1;
            repeat (2) @(negedge clock);
            vsync = 1'b0;
            repeat (2) @(negedge clock);
            nframes++;
        end
        if (mv != NONE) set_btn(mv, 1'b0);
        @(negedge clock);
    endtask

    task automatic run_to(input int target);
        run_frames(NONE, target - nframes);
    endtask

    task automatic chk_home(input string tag);
        chk({tag, "_state"}, int'(game_state), 0);
        chk({tag, "_x"}, int'(player_loc_x), 192);
        chk({tag, "_y"}, int'(player_loc_y), 128);
        chk({tag, "_dir"}, int'(player_direction), 2);
        chk({tag, "_time"}, int'(time_left), 120);
        chk({tag, "_points"}, int'(point_total), 0);
        chk({tag, "_orders"}, int'(orders), 0);
        chk({tag, "_held"}, int'(player_state), 0);
        chk({tag, "_board"}, int'(object_grid[0][6]), 0);
    endtask

    initial begin
        // menu: each press then the expected letters, leftmost first
        wv[0]  = '{B_LEFT,  LA, LA, LA};
        wv[1]  = '{B_UP,    LB, LA, LA};
        wv[2]  = '{B_UP,    LC, LA, LA};
        wv[3]  = '{B_RIGHT, LC, LA, LA};
        wv[4]  = '{B_DOWN,  LC, LZ, LA};
        wv[5]  = '{B_DOWN,  LC, LY, LA};
        wv[6]  = '{B_RIGHT, LC, LY, LA};
        wv[7]  = '{B_UP,    LC, LY, LB};
        wv[8]  = '{B_RIGHT, LC, LY, LB};
        wv[9]  = '{B_UP,    LC, LY, LC};
        wv[10] = '{B_DOWN,  LC, LY, LB};

        // round script: move (act 0) or press carry (1) / chop (2); then x, y, dir, held, optional tile
        st[0]  = '{B_RIGHT, 10,  0, 212, 128, 1, 0, -1, 0, 0, 0};
        st[1]  = '{NONE,    1,   1, 212, 128, 1, 0, -1, 0, 0, 0};
        st[2]  = '{B_RIGHT, 200, 0, 352, 128, 1, 0, -1, 0, 0, 0};
        st[3]  = '{B_LEFT,  170, 0, 32,  128, 3, 0, -1, 0, 0, 0};
        st[4]  = '{B_UP,    10,  0, 32,  108, 0, 0, -1, 0, 0, 0};
        st[5]  = '{B_LEFT,  1,   0, 32,  108, 3, 0, -1, 0, 0, 0};
        st[6]  = '{NONE,    1,   1, 32,  108, 3, 1, 3, 0, 0, 0};
        st[7]  = '{B_UP,    40,  0, 32,  32,  0, 1, -1, 0, 0, 0};
        st[8]  = '{B_RIGHT, 80,  0, 192, 32,  1, 1, -1, 0, 0, 0};
        st[9]  = '{B_UP,    1,   0, 192, 32,  0, 1, -1, 0, 0, 0};
        st[10] = '{NONE,    1,   1, 192, 32,  0, 0, 0, 6, 1, 0};
        st[11] = '{NONE,    1,   2, 192, 32,  0, 0, 0, 6, 1, 1};
        st[12] = '{NONE,    3,   2, 192, 32,  0, 0, 0, 6, 2, 0};
        st[13] = '{B_DOWN,  80,  0, 192, 192, 2, 0, 0, 6, 2, 0};
        st[14] = '{NONE,    1,   1, 192, 192, 2, 3, 7, 6, 0, 0};
        st[15] = '{B_UP,    80,  0, 192, 32,  0, 3, -1, 0, 0, 0};
        st[16] = '{NONE,    1,   1, 192, 32,  0, 4, 0, 6, 0, 0};
        st[17] = '{B_DOWN,  32,  0, 192, 96,  2, 4, -1, 0, 0, 0};
        st[18] = '{B_RIGHT, 80,  0, 352, 96,  1, 4, -1, 0, 0, 0};
        st[19] = '{NONE,    1,   1, 352, 96,  1, 0, -1, 0, 0, 0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_home("reset");
        chk("reset_name0", int'(team_name[0]), LA);
        chk("reset_name2", int'(team_name[2]), LA);

        for (int i = 0; i < 11; i++) begin
            press(wv[i].btn, 1);
            chk($sformatf("menu%0d_l0", i), int'(team_name[0]), wv[i].e0);
            chk($sformatf("menu%0d_l1", i), int'(team_name[1]), wv[i].e1);
            chk($sformatf("menu%0d_l2", i), int'(team_name[2]), wv[i].e2);
        end

        press(B_CHOP, 1);
        chk("start_state", int'(game_state), 1);
        chk("start_time", int'(time_left), 120);

        for (int i = 0; i < 20; i++) begin
            if (st[i].act == 0)      run_frames(st[i].mv, st[i].n);
            else if (st[i].act == 1) press(B_CARRY, st[i].n);
            else                     press(B_CHOP, st[i].n);
            chk($sformatf("step%0d_x", i), int'(player_loc_x), st[i].ex);
            chk($sformatf("step%0d_y", i), int'(player_loc_y), st[i].ey);
            chk($sformatf("step%0d_dir", i), int'(player_direction), st[i].edir);
            chk($sformatf("step%0d_held", i), int'(player_state), st[i].est);
            if (st[i].tr >= 0) begin
                chk($sformatf("step%0d_obj", i), int'(object_grid[st[i].tr][st[i].tc]), st[i].eobj);
                chk($sformatf("step%0d_chops", i), int'(time_grid[st[i].tr][st[i].tc]), st[i].etg);
            end
            if (i == 18) begin
                // 784 frames in: first order spawned at 10 s, aged at 11..13 s
                chk("pre_serve_orders", int'(orders), 1);
                chk("pre_serve_otime0", int'(order_times[0]), 17);
                chk("pre_serve_time", int'(time_left), 107);
                chk("pre_serve_points", int'(point_total), 0);
            end
        end
        chk("serve_points", int'(point_total), 20);
        chk("serve_orders", int'(orders), 0);

        // 45 s: order from 20 s expired at 40 s (-10); slots hold the 30 s and 40 s spawns
        run_to(2700);
        chk("t45_points", int'(point_total), 10);
        chk("t45_orders", int'(orders), 3);
        chk("t45_otime0", int'(order_times[0]), 15);
        chk("t45_otime1", int'(order_times[1]), 5);

        // 60.5 s: expiries at 50 s and 60 s, the second one floored at zero
        run_to(3630);
        chk("t60_points", int'(point_total), 0);
        chk("t60_orders", int'(orders), 3);
        chk("t60_otime0", int'(order_times[0]), 20);
        chk("t60_otime1", int'(order_times[1]), 10);
        chk("t60_time", int'(time_left), 60);

        run_to(7199);
        chk("t119_time", int'(time_left), 1);
        chk("t119_state", int'(game_state), 1);
        run_to(7200);
        chk("over_state", int'(game_state), 2);
        chk("over_time", int'(time_left), 0);

        run_frames(B_LEFT, 5);
        press(B_CARRY, 1);
        chk("frozen_x", int'(player_loc_x), 352);
        chk("frozen_dir", int'(player_direction), 1);
        chk("frozen_time", int'(time_left), 0);
        chk("frozen_state", int'(game_state), 2);

        press(B_CHOP, 1);
        chk_home("restart");
        chk("restart_name0", int'(team_name[0]), LC);
        chk("restart_name1", int'(team_name[1]), LY);
        chk("restart_name2", int'(team_name[2]), LB);
        press(B_UP, 1);
        chk("restart_cursor0", int'(team_name[0]), LD);

        press(B_CHOP, 1);
        chk("round2_state", int'(game_state), 1);
        run_frames(B_RIGHT, 5);
        chk("round2_x", int'(player_loc_x), 202);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_home("midreset");
        chk("midreset_name0", int'(team_name[0]), LA);
        chk("midreset_name1", int'(team_name[1]), LA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
